// File: rtl/regfile_dump_reader.sv
// Streams a contiguous, wrapping range of register-file words out over valid/ready.
// One combinational read port is walked one address per word: READ samples, SEND offers.

module regfile_dump_reader #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] first_addr,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StSend,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0] last_q, last_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [ADDR_WIDTH-1:0] out_index_q, out_index_d;

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    last_d      = last_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          last_d    = last_addr;
          rd_addr_d = first_addr;
          state_d   = StRead;
        end
      end
      StRead: begin
        out_data_d  = rd_data;
        out_index_d = rd_addr_q;
        state_d     = StSend;
      end
      StSend: begin
        if (out_ready) begin
          if (rd_addr_q == last_q) begin
            state_d = StDone;
          end else begin
            // Natural overflow of the address gives the wrap through the top register.
            rd_addr_d = rd_addr_q + 1'b1;
            state_d   = StRead;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      rd_addr_q   <= '0;
      last_q      <= '0;
      out_data_q  <= '0;
      out_index_q <= '0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      last_q      <= last_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
    end
  end

  assign rd_addr   = rd_addr_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_valid = (state_q == StSend);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);

endmodule

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Sequential read-side master for the 8×16 register file: on a start pulse it walks a contiguous (wrapping) range of register addresses through one combinational read port and streams each word out over a valid/ready handshake. It sits between the register file's read port and a debug/trace sink, and is the reading counterpart to the datapath's writeback path. It is used for register dumps, context save, and bench-side state inspection without touching the write port.

## Interface
- DATA_WIDTH, 16, register word width
- ADDR_WIDTH, 3, register address width; number of registers is 2**ADDR_WIDTH
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; 0 forces all state to reset values immediately
- start  in  1  single-cycle request to begin a dump; sampled only in IDLE
- first_addr  in  ADDR_WIDTH  first register of the range; latched on accepted start
- last_addr  in  ADDR_WIDTH  last register of the range; latched on accepted start
- rd_addr  out  ADDR_WIDTH  address driven to the register file read port (registered)
- rd_data  in  DATA_WIDTH  combinational read data returned for rd_addr
- out_valid  out  1  out_data/out_index hold a word
- out_ready  in  1  sink accepts the word when out_valid & out_ready at a rising edge
- out_data  out  DATA_WIDTH  captured register value (registered)
- out_index  out  ADDR_WIDTH  register number of out_data (registered)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last word is accepted

## Operation
- States: IDLE, READ, SEND, DONE (2-bit encoding, implementer's choice).
- IDLE: busy=0, out_valid=0. start=1 at an edge → latch last_addr into last register, rd_addr←first_addr, go READ.
- READ: rd_addr is stable for the full cycle; at the edge capture out_data←rd_data, out_index←rd_addr, out_valid←1, go SEND.
- SEND: out_valid=1; out_data/out_index held constant until handshake. On out_valid & out_ready at an edge: out_valid←0; if rd_addr==last → go DONE; else rd_addr←rd_addr+1 (mod 2**ADDR_WIDTH), go READ.
- DONE: done=1 for this cycle only, busy=1; next edge → IDLE.
- Word count = ((last_addr − first_addr) mod 2**ADDR_WIDTH) + 1; first==last dumps exactly one word; last<first wraps through the top address to 0.
- start while busy (READ/SEND/DONE) is ignored; no queuing. first_addr/last_addr changes after acceptance have no effect.
- out_ready while out_valid=0 has no effect.
- Register file writes in the same cycle as a READ are visible if they complete before the sampling rising edge (write port updates on falling edge); no hazard logic required.

## Timing
- Reset values: state=IDLE, rd_addr=0, out_data=0, out_index=0, out_valid=0, busy=0, done=0.
- Reset asserted mid-dump: all outputs return to reset values asynchronously; no done pulse; the dump is discarded.
- start accepted at edge N → rd_addr=first_addr and busy=1 after edge N; out_valid=1 after edge N+1.
- Minimum 2 cycles per word (READ + SEND with out_ready held high); full 8-word dump with out_ready=1 is 16 cycles from accept to DONE entry, done high in cycle 17, busy low after the next edge.
- Each stalled cycle (out_ready=0 in SEND) adds exactly one cycle; no data or index change during stall.
- rd_addr never changes in READ; it changes only on the handshake edge or the start edge.
- done and out_valid are never high in the same cycle.

## Test plan
- Full dump: preload r[i]=16'h1000+i, first=0,last=7, out_ready=1 → 8 words, index 0..7, data 16'h1000..16'h1007, done pulse exactly 16 cycles after start edge, busy then low.
- Wrap: first=6,last=1 → indices 6,7,0,1 in order, data matches, exactly 4 handshakes.
- Single word and backpressure: first=last=3, out_ready low for 5 cycles after out_valid → out_data=r[3], out_index=3 stable across all 5 stall cycles, one handshake, done follows.
- Start while busy: pulse start with first=0 during a 0..7 dump → ignored, dump completes unchanged with 8 words, no second dump.
- Reset mid-dump: assert reset (0) while in SEND at index 4 → out_valid, busy, done, rd_addr, out_data immediately 0; after release, no output until next start; new dump 2..2 returns r[2].
- Write during dump: change r[5] on a falling edge while rd_addr=5 in READ → out_data carries the new value.
